// File: rtl/proc_rom_sequencer_if.sv
// Fetch/execute bus between the program ROM, the processor and the instruction sequencer.
// The master side is the host/ROM/processor environment; the slave side is the sequencer.
interface proc_rom_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
);
    logic              Start;
    logic              Stop;
    logic [ADDR_W-1:0] StartAddr;
    logic [ADDR_W-1:0] LastAddr;
    logic [DATA_W-1:0] ROMData;
    logic              Done;
    logic [ADDR_W-1:0] ROMAddr;
    logic [DATA_W-1:0] DIN;
    logic              Run;
    logic              Busy;
    logic              Halted;
    logic              Error;
    logic [7:0]        InstrCount;

    modport master (
        output Start, Stop, StartAddr, LastAddr, ROMData, Done,
        input  ROMAddr, DIN, Run, Busy, Halted, Error, InstrCount
    );

    modport slave (
        input  Start, Stop, StartAddr, LastAddr, ROMData, Done,
        output ROMAddr, DIN, Run, Busy, Halted, Error, InstrCount
    );
endinterface

// File: rtl/proc_rom_sequencer.sv
// Program-counter based instruction fetch sequencer: one Run pulse per instruction,
// mvi immediate supplied from PC+1, stop at LastAddr, on request, or on watchdog timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped after reset or a Stop request; waits for Start
// S_FETCH | ROMAddr = PC, ROM registers the instruction address
// S_ISSUE | instruction on DIN, Run pulse, ROMAddr advanced to PC+1
// S_EXEC  | processor executing; wait for Done or watchdog
// S_HALT  | LastAddr reached or watchdog fired; waits for Start
module proc_rom_sequencer #(
    parameter int          ADDR_W  = 5,
    parameter int          DATA_W  = 9,
    parameter logic [2:0]  MVI_OP  = 3'b001,
    parameter int          TIMEOUT = 15
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    proc_rom_sequencer_if.slave    bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALT} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_run;
    logic              r_busy;
    logic              r_halted;
    logic              r_error;
    logic [7:0]        r_instr_count;
    logic              r_stop;
    logic              r_is_mvi;
    logic [TMR_W-1:0]  r_timer;

    logic [ADDR_W-1:0] w_pc_p1;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_span_last;
    logic              w_stop_now;

    assign w_pc_p1     = r_pc + ADDR_W'(1);
    assign w_next_pc   = r_is_mvi ? (r_pc + ADDR_W'(2)) : w_pc_p1;
    assign w_span_last = (r_pc == bus.LastAddr) || (r_is_mvi && (w_pc_p1 == bus.LastAddr));
    // A Stop arriving in the same cycle as Done still ends the run at this boundary.
    assign w_stop_now  = r_stop || bus.Stop;

    // DIN must follow ROMData in the same cycle, so it is gated from the state register.
    assign bus.DIN        = ((r_state == S_ISSUE) || (r_state == S_EXEC)) ? bus.ROMData : '0;
    assign bus.ROMAddr    = r_rom_addr;
    assign bus.Run        = r_run;
    assign bus.Busy       = r_busy;
    assign bus.Halted     = r_halted;
    assign bus.Error      = r_error;
    assign bus.InstrCount = r_instr_count;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_rom_addr    <= '0;
            r_run         <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_error       <= 1'b0;
            r_instr_count <= '0;
            r_stop        <= 1'b0;
            r_is_mvi      <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_run <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.Start) begin
                        r_pc          <= bus.StartAddr;
                        r_rom_addr    <= bus.StartAddr;
                        r_instr_count <= '0;
                        r_error       <= 1'b0;
                        r_stop        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_halted      <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.Stop) r_stop <= 1'b1;
                    r_rom_addr <= w_pc_p1;
                    r_run      <= 1'b1;
                    r_state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.Stop) r_stop <= 1'b1;
                    r_is_mvi <= (bus.ROMData[DATA_W-1 -: 3] == MVI_OP);
                    r_timer  <= '0;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (bus.Stop) r_stop <= 1'b1;
                    if (bus.Done) begin
                        r_instr_count <= r_instr_count + 8'd1;
                        r_pc          <= w_next_pc;
                        r_rom_addr    <= w_next_pc;
                        if (w_span_last) begin
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else if (w_stop_now) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_error  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
